scan_sig_checker: RTL and testbench

// - Scan-out integrity stage: consumes the serial bit stream leaving a scan chain and folds

---
 rtl/scan_sig_checker_if.sv | 27 ++
 rtl/scan_sig_checker.sv | 95 +++++++++
 tb/tb_scan_sig_checker.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/scan_sig_checker_if.sv
// Handshake/result bundle for scan_sig_checker: the stimulus side drives master,
// the checker connects to slave.
interface scan_sig_checker_if #(
  parameter int SIG_W = 16,
  parameter int CNT_W = 7
);
  logic             start;
  logic             scan_out_bit;
  logic             scan_valid;
  logic [SIG_W-1:0] exp_sig;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [CNT_W-1:0] bit_cnt;
  logic             fail_sticky;

  modport master (
    output start, scan_out_bit, scan_valid, exp_sig,
    input  busy, done, pass, signature, bit_cnt, fail_sticky
  );

  modport slave (
    input  start, scan_out_bit, scan_valid, exp_sig,
    output busy, done, pass, signature, bit_cnt, fail_sticky
  );
endinterface

// File: rtl/scan_sig_checker.sv
// Folds each CHAIN_LEN-bit scan-out frame into a CRC signature and compares it with the
// expected value. Optional macro SCAN_SIG_STICKY_EN adds a mismatch flag held until reset.
module scan_sig_checker #(
  parameter int               CHAIN_LEN = 128,
  parameter int               SIG_W     = 16,
  parameter logic [SIG_W-1:0] POLY      = 16'h1021,
  parameter logic [SIG_W-1:0] SEED      = 16'hFFFF
) (
  input logic              clk,
  input logic              reset,
  scan_sig_checker_if.slave sif
);
  localparam int               CNT_W = $clog2(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, CHECK} state_t;

  state_t           state_q, state_d;
  logic [SIG_W-1:0] sig_q, exp_q, sig_next;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q, pass_q, busy;
  logic             fb;

  // Galois-style shift: feedback is the outgoing MSB xor the incoming scan bit.
  assign fb       = sig_q[SIG_W-1] ^ sif.scan_out_bit;
  assign sig_next = {sig_q[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE:    if (sif.start) state_d = CAPTURE;
      CAPTURE: begin
        busy = 1'b1;
        if (sif.scan_valid && cnt_q == LAST) state_d = CHECK;
      end
      CHECK: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q  <= SEED;
      exp_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (sif.start) begin
          sig_q  <= SEED;
          cnt_q  <= '0;
          exp_q  <= sif.exp_sig;
          pass_q <= 1'b0;
        end
        CAPTURE: if (sif.scan_valid) begin
          sig_q <= sig_next;
          cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
        CHECK: begin
          pass_q <= (sig_q == exp_q);
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SCAN_SIG_STICKY_EN
  logic fail_q;
  always_ff @(posedge clk) begin
    if (reset)                                   fail_q <= 1'b0;
    else if (state_q == CHECK && sig_q != exp_q) fail_q <= 1'b1;
  end
  assign sif.fail_sticky = fail_q;
`else
  assign sif.fail_sticky = 1'b0;
`endif

  assign sif.busy      = busy;
  assign sif.done      = done_q;
  assign sif.pass      = pass_q;
  assign sif.signature = sig_q;
  assign sif.bit_cnt   = cnt_q;
endmodule

// File: tb/tb_scan_sig_checker.sv
// Directed bench for scan_sig_checker: a 4-bit-chain instance driven from a vector table
// plus hand sequences, and a default-parameter instance checked against a CRC model.
module tb_scan_sig_checker;
`ifdef SCAN_SIG_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scan_sig_checker_if #(.SIG_W(16), .CNT_W(2)) i4 ();
  scan_sig_checker_if #(.SIG_W(16), .CNT_W(7)) i128 ();

  scan_sig_checker #(.CHAIN_LEN(4), .SIG_W(16), .POLY(16'h1021), .SEED(16'h0000))
    u4 (.clk(clk), .reset(reset), .sif(i4.slave));
  scan_sig_checker u128 (.clk(clk), .reset(reset), .sif(i128.slave));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        st, v, b;
    logic [15:0] xs;
    logic        e_busy, e_done, e_pass, e_stk;
    logic [15:0] e_sig;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the small instance, then sample 1ns after the edge.
  task automatic cyc(input logic st, input logic v, input logic b, input logic [15:0] xs);
    i4.start = st; i4.scan_valid = v; i4.scan_out_bit = b; i4.exp_sig = xs;
    @(posedge clk); #1;
    i4.start = 1'b0; i4.scan_valid = 1'b0; i4.scan_out_bit = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic busy, input logic done, input logic pass,
                         input logic [15:0] sig, input logic [1:0] cnt, input logic stk);
    chk({tag, ".busy"}, 32'(i4.busy), 32'(busy));
    chk({tag, ".done"}, 32'(i4.done), 32'(done));
    chk({tag, ".pass"}, 32'(i4.pass), 32'(pass));
    chk({tag, ".sig"},  32'(i4.signature), 32'(sig));
    chk({tag, ".cnt"},  32'(i4.bit_cnt), 32'(cnt));
    chk({tag, ".stk"},  32'(i4.fail_sticky), 32'(stk));
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] s, input logic b);
    logic f;
    f = s[15] ^ b;
    return {s[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
  endfunction

  task automatic run128(input logic [15:0] xs, input logic exp_pass, input logic [15:0] exp_sig);
    bit seen;
    i128.start = 1'b1; i128.exp_sig = xs;
    @(posedge clk); #1;
    i128.start = 1'b0;
    for (int i = 0; i < 128; i++) begin
      i128.scan_valid = 1'b1; i128.scan_out_bit = 1'b0;
      @(posedge clk); #1;
    end
    i128.scan_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(posedge clk); #1;
      seen = i128.done;
    end
    chk("d128.done_seen", 32'(seen), 32'd1);
    chk("d128.pass", 32'(i128.pass), 32'(exp_pass));
    chk("d128.sig", 32'(i128.signature), 32'(exp_sig));
  endtask

  initial begin
    logic [15:0] ref_sig;
    i4.start = 0; i4.scan_valid = 0; i4.scan_out_bit = 0; i4.exp_sig = 0;
    i128.start = 0; i128.scan_valid = 0; i128.scan_out_bit = 0; i128.exp_sig = 0;

    // frame 1 good, frame 2 (back-to-back) bad, frame 3 good again
    //          st  v  b  xs        busy done pass stk  sig       cnt
    tbl.push_back('{1, 0, 0, 16'h8108, 1, 0, 0, 0,   16'h0000, 0});
    tbl.push_back('{0, 1, 1, 16'h0000, 1, 0, 0, 0,   16'h1021, 1});
    tbl.push_back('{0, 1, 0, 16'h0000, 1, 0, 0, 0,   16'h2042, 2});
    tbl.push_back('{0, 1, 0, 16'h0000, 1, 0, 0, 0,   16'h4084, 3});
    tbl.push_back('{0, 1, 0, 16'h0000, 1, 0, 0, 0,   16'h8108, 0});
    tbl.push_back('{0, 1, 1, 16'h0000, 0, 1, 1, 0,   16'h8108, 0});
    tbl.push_back('{1, 0, 0, 16'h0000, 1, 0, 0, 0,   16'h0000, 0});
    tbl.push_back('{0, 1, 1, 16'h0000, 1, 0, 0, 0,   16'h1021, 1});
    tbl.push_back('{0, 1, 0, 16'h0000, 1, 0, 0, 0,   16'h2042, 2});
    tbl.push_back('{0, 1, 0, 16'h0000, 1, 0, 0, 0,   16'h4084, 3});
    tbl.push_back('{0, 1, 0, 16'h0000, 1, 0, 0, 0,   16'h8108, 0});
    tbl.push_back('{0, 0, 0, 16'h0000, 0, 1, 0, STK, 16'h8108, 0});
    tbl.push_back('{1, 0, 0, 16'h8108, 1, 0, 0, STK, 16'h0000, 0});
    tbl.push_back('{0, 1, 1, 16'h0000, 1, 0, 0, STK, 16'h1021, 1});
    tbl.push_back('{0, 1, 0, 16'h0000, 1, 0, 0, STK, 16'h2042, 2});
    tbl.push_back('{0, 1, 0, 16'h0000, 1, 0, 0, STK, 16'h4084, 3});
    tbl.push_back('{0, 1, 0, 16'h0000, 1, 0, 0, STK, 16'h8108, 0});
    tbl.push_back('{0, 0, 0, 16'h0000, 0, 1, 1, STK, 16'h8108, 0});
    tbl.push_back('{0, 0, 0, 16'h0000, 0, 0, 1, STK, 16'h8108, 0});

    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk_all("rst", 0, 0, 0, 16'h0000, 0, 0);
    chk("rst.d128.sig", 32'(i128.signature), 32'h0000FFFF);

    foreach (tbl[i]) begin
      cyc(tbl[i].st, tbl[i].v, tbl[i].b, tbl[i].xs);
      chk_all($sformatf("vec%0d", i), tbl[i].e_busy, tbl[i].e_done, tbl[i].e_pass,
              tbl[i].e_sig, tbl[i].e_cnt, tbl[i].e_stk);
    end

    // stalls of 3 cycles between bits, with a start pulse mid-frame
    reset = 1'b1; cyc(0, 0, 0, 0); reset = 1'b0;
    cyc(1, 0, 0, 16'h8108);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0); cyc(1, 0, 0, 16'h0000); cyc(0, 0, 0, 0);
    chk_all("gap.hold", 1, 0, 0, 16'h1021, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      if (i < 2) begin cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); end
    end
    chk_all("gap.check", 1, 0, 0, 16'h8108, 0, 0);
    cyc(0, 1, 1, 0);
    chk_all("gap.done", 0, 1, 1, 16'h8108, 0, 0);

    // scan_valid alongside start is not absorbed
    cyc(1, 1, 1, 16'h0000);
    chk_all("sv.start", 1, 0, 0, 16'h0000, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk_all("sv.done", 0, 1, 1, 16'h0000, 0, 0);

    // reset mid-frame discards the frame
    cyc(1, 0, 0, 16'h8108);
    cyc(0, 1, 1, 0); cyc(0, 1, 0, 0);
    chk_all("mid.pre", 1, 0, 0, 16'h2042, 2, 0);
    reset = 1'b1; cyc(0, 1, 0, 0); reset = 1'b0;
    chk_all("mid.rst", 0, 0, 0, 16'h0000, 0, 0);
    cyc(1, 0, 0, 16'h8108);
    cyc(0, 1, 1, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk_all("mid.new", 0, 1, 1, 16'h8108, 0, 0);

    // default parameters: 128 zero bits from SEED=FFFF
    ref_sig = 16'hFFFF;
    for (int i = 0; i < 128; i++) ref_sig = crc_step(ref_sig, 1'b0);
    run128(ref_sig, 1'b1, ref_sig);
    run128(ref_sig ^ 16'h0001, 1'b0, ref_sig);
    chk("d128.stk", 32'(i128.fail_sticky), 32'(STK));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
